// File: rtl/mem_stage_pkg.sv
// Shared types and encodings for the data-memory pipeline stage.
// op_mem field layout, access sizes, FSM states and the latched record layouts.
package mem_stage_pkg;

    localparam int XLEN     = 32;
    localparam int BYPASS_W = 38;

    localparam int OPM_LOAD  = 0;
    localparam int OPM_STORE = 1;
    localparam int OPM_UNS   = 2;
    localparam int OPM_SIZE  = 3;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_CANCEL
    } state_e;

    // Writeback-facing fields captured when an instruction is accepted.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] result;
        logic            wreg_en;
        logic [4:0]      wreg_index;
        logic            excp;
        logic            ale;
        logic [XLEN-1:0] badv;
    } hdr_t;

    typedef struct packed {
        logic            wr;
        logic [3:0]      wstrb;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic       load;
        logic       uns;
        logic [1:0] size;
        logic [1:0] addr_lo;
    } meta_t;

endpackage

// File: rtl/mem_align.sv
// Misalignment check, store strobe/data lane placement and load extract/extend.
// Purely combinational (zero latency); no flow control.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic            is_mem_i,
    input  logic            is_store_i,
    input  logic [1:0]      size_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] st_data_i,
    output logic            ale_o,
    output logic [3:0]      wstrb_o,
    output logic [XLEN-1:0] wdata_o,
    input  logic            ld_uns_i,
    input  logic [1:0]      ld_size_i,
    input  logic [1:0]      ld_addr_lo_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] ld_data_o
);

    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    always_comb begin
        ale_o = is_mem_i & (((size_i == SZ_H) & addr_lo_i[0]) |
                            ((size_i == SZ_W) & (addr_lo_i != 2'b00)));
        case (size_i)
            SZ_B: begin
                wdata_o = {4{st_data_i[7:0]}};
                wstrb_o = 4'b0001 << addr_lo_i;
            end
            SZ_H: begin
                wdata_o = {2{st_data_i[15:0]}};
                wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata_o = st_data_i;
                wstrb_o = 4'b1111;
            end
        endcase
        if (!is_store_i) begin
            wstrb_o = 4'b0000;
        end
    end

    always_comb begin
        ld_b = 8'(rdata_i >> {ld_addr_lo_i, 3'b000});
        ld_h = 16'(rdata_i >> {ld_addr_lo_i[1], 4'b0000});
        case (ld_size_i)
            SZ_B:    ld_data_o = {{24{ld_b[7] & ~ld_uns_i}}, ld_b};
            SZ_H:    ld_data_o = {{16{ld_h[15] & ~ld_uns_i}}, ld_h};
            default: ld_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: one load/store per instruction on a split addr/data SRAM port.
// Latency 1 cycle for non-memory ops, until data_ok for accesses; stalls execute while busy or blocked.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                excp_flush,
    input  logic                ertn_flush,
    input  logic                left_valid,
    output logic                left_ready,
    input  logic [ADDR_W-1:0]   ex_pc,
    input  logic [DATA_W-1:0]   ex_result,
    input  logic [DATA_W-1:0]   ex_store_data,
    input  logic [5:0]          ex_op_mem,
    input  logic                ex_wreg_en,
    input  logic [4:0]          ex_wreg_index,
    input  logic                ex_excp,
    output logic                data_req,
    output logic                data_wr,
    output logic [3:0]          data_wstrb,
    output logic [ADDR_W-1:0]   data_addr,
    output logic [DATA_W-1:0]   data_wdata,
    input  logic                data_addr_ok,
    input  logic                data_data_ok,
    input  logic [DATA_W-1:0]   data_rdata,
    output logic                right_valid,
    input  logic                right_ready,
    output logic [ADDR_W-1:0]   mem_pc,
    output logic [DATA_W-1:0]   mem_result,
    output logic                mem_wreg_en,
    output logic [4:0]          mem_wreg_index,
    output logic                mem_excp,
    output logic                mem_ale,
    output logic [ADDR_W-1:0]   mem_badv,
    output logic [BYPASS_W-1:0] mem_bypass,
    output logic                mem_load_busy
);

    state_e state_q, state_d;
    logic   valid_q, valid_d;
    hdr_t   hdr_q, hdr_d;
    req_t   req_q, req_d;
    meta_t  meta_q, meta_d;

    logic            flush, accept, ex_mem, ale, fwd_en;
    logic [3:0]      al_wstrb;
    logic [XLEN-1:0] al_wdata, ld_data;
    logic            unused_op_rsvd;

    assign unused_op_rsvd = ex_op_mem[5];
    assign ex_mem = ex_op_mem[OPM_LOAD] | ex_op_mem[OPM_STORE];

    mem_align u_align (
        .is_mem_i     (ex_mem),
        .is_store_i   (ex_op_mem[OPM_STORE]),
        .size_i       (ex_op_mem[OPM_SIZE +: 2]),
        .addr_lo_i    (ex_result[1:0]),
        .st_data_i    (ex_store_data),
        .ale_o        (ale),
        .wstrb_o      (al_wstrb),
        .wdata_o      (al_wdata),
        .ld_uns_i     (meta_q.uns),
        .ld_size_i    (meta_q.size),
        .ld_addr_lo_i (meta_q.addr_lo),
        .rdata_i      (data_rdata),
        .ld_data_o    (ld_data)
    );

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        hdr_d   = hdr_q;
        req_d   = req_q;
        meta_d  = meta_q;

        flush      = excp_flush | ertn_flush;
        left_ready = (state_q == ST_IDLE) & (~valid_q | right_ready) & ~flush;
        accept     = left_valid & left_ready;

        // Valid only drops on handoff once the access (if any) has finished.
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
        end else if (right_ready && state_q == ST_IDLE) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            hdr_d.pc         = ex_pc;
            hdr_d.result     = ex_result;
            hdr_d.wreg_en    = ex_wreg_en & ~ale & ~ex_excp;
            hdr_d.wreg_index = ex_wreg_index;
            hdr_d.excp       = ex_excp | ale;
            hdr_d.ale        = ale;
            hdr_d.badv       = ale ? ex_result : '0;
            req_d.wr         = ex_op_mem[OPM_STORE];
            req_d.wstrb      = al_wstrb;
            req_d.addr       = ex_result;
            req_d.wdata      = al_wdata;
            meta_d.load      = ex_op_mem[OPM_LOAD];
            meta_d.uns       = ex_op_mem[OPM_UNS];
            meta_d.size      = ex_op_mem[OPM_SIZE +: 2];
            meta_d.addr_lo   = ex_result[1:0];
        end

        case (state_q)
            ST_IDLE: begin
                if (accept && ex_mem && !ale && !ex_excp) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (flush) begin
                    state_d = data_addr_ok ? ST_CANCEL : ST_IDLE;
                end else if (data_addr_ok) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A response landing with the flush completes the access; no cancel needed.
                if (data_data_ok) begin
                    state_d = ST_IDLE;
                    if (meta_q.load && !flush) begin
                        hdr_d.result = ld_data;
                    end
                end else if (flush) begin
                    state_d = ST_CANCEL;
                end
            end
            ST_CANCEL: begin
                if (data_data_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            hdr_q   <= '0;
            req_q   <= '0;
            meta_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            hdr_q   <= hdr_d;
            req_q   <= req_d;
            meta_q  <= meta_d;
        end
    end

    assign data_req       = (state_q == ST_REQ);
    assign data_wr        = req_q.wr;
    assign data_wstrb     = req_q.wstrb;
    assign data_addr      = req_q.addr;
    assign data_wdata     = req_q.wdata;

    assign right_valid    = valid_q & (state_q == ST_IDLE);
    assign mem_pc         = hdr_q.pc;
    assign mem_result     = hdr_q.result;
    assign mem_wreg_en    = hdr_q.wreg_en;
    assign mem_wreg_index = hdr_q.wreg_index;
    assign mem_excp       = hdr_q.excp;
    assign mem_ale        = hdr_q.ale;
    assign mem_badv       = hdr_q.badv;

    assign fwd_en         = valid_q & hdr_q.wreg_en & (state_q == ST_IDLE);
    assign mem_bypass     = {hdr_q.result, hdr_q.wreg_index, fwd_en};
    assign mem_load_busy  = valid_q & (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of single-instruction vectors plus
// hand-written flush, backpressure and reset sequences.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset, excp_flush, ertn_flush;
    logic        left_valid, left_ready;
    logic [31:0] ex_pc, ex_result, ex_store_data;
    logic [5:0]  ex_op_mem;
    logic        ex_wreg_en;
    logic [4:0]  ex_wreg_index;
    logic        ex_excp;
    logic        data_req, data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        right_valid, right_ready;
    logic [31:0] mem_pc, mem_result;
    logic        mem_wreg_en;
    logic [4:0]  mem_wreg_index;
    logic        mem_excp, mem_ale;
    logic [31:0] mem_badv;
    logic [37:0] mem_bypass;
    logic        mem_load_busy;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .reset(reset), .excp_flush(excp_flush), .ertn_flush(ertn_flush),
        .left_valid(left_valid), .left_ready(left_ready),
        .ex_pc(ex_pc), .ex_result(ex_result), .ex_store_data(ex_store_data),
        .ex_op_mem(ex_op_mem), .ex_wreg_en(ex_wreg_en), .ex_wreg_index(ex_wreg_index),
        .ex_excp(ex_excp),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .right_valid(right_valid), .right_ready(right_ready),
        .mem_pc(mem_pc), .mem_result(mem_result), .mem_wreg_en(mem_wreg_en),
        .mem_wreg_index(mem_wreg_index), .mem_excp(mem_excp), .mem_ale(mem_ale),
        .mem_badv(mem_badv), .mem_bypass(mem_bypass), .mem_load_busy(mem_load_busy)
    );

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic        wen_in;
        logic        exc_in;
        logic        exp_req;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_result;
        logic        exp_wen;
        logic        exp_ale;
        logic        exp_excp;
    } vec_t;

    localparam int NV = 15;
    vec_t vt [NV];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] res, input logic [31:0] sd,
                         input logic wen, input logic [4:0] idx, input logic exc);
        @(negedge clk);
        left_valid    = 1'b1;
        ex_pc         = 32'h8000_0000 + res;
        ex_result     = res;
        ex_store_data = sd;
        ex_op_mem     = op;
        ex_wreg_en    = wen;
        ex_wreg_index = idx;
        ex_excp       = exc;
        #1 chk("accept_ready", {63'd0, left_ready}, 64'd1);
        @(negedge clk);
        left_valid = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog: simulation did not finish");
    end

    initial begin
        //             op         addr          sdata         rdata        wen exc req strb   wdata         result       wen ale exc
        vt[0]  = '{6'b010010, 32'h1000, 32'hAABBCCDD, 32'h0,        0, 0, 1, 4'hF,   32'hAABBCCDD, 32'h1000,     0, 0, 0};
        vt[1]  = '{6'b000001, 32'h1003, 32'h0,        32'h80FFFFFF, 1, 0, 1, 4'h0,   32'h0,        32'hFFFFFF80, 1, 0, 0};
        vt[2]  = '{6'b000101, 32'h1003, 32'h0,        32'h80FFFFFF, 1, 0, 1, 4'h0,   32'h0,        32'h00000080, 1, 0, 0};
        vt[3]  = '{6'b001001, 32'h1002, 32'h0,        32'h80011234, 1, 0, 1, 4'h0,   32'h0,        32'hFFFF8001, 1, 0, 0};
        vt[4]  = '{6'b001101, 32'h1000, 32'h0,        32'h8001F234, 1, 0, 1, 4'h0,   32'h0,        32'h0000F234, 1, 0, 0};
        vt[5]  = '{6'b010001, 32'h2004, 32'h0,        32'h12345678, 1, 0, 1, 4'h0,   32'h0,        32'h12345678, 1, 0, 0};
        vt[6]  = '{6'b000010, 32'h1001, 32'h11223344, 32'h0,        0, 0, 1, 4'b0010, 32'h44444444, 32'h1001,    0, 0, 0};
        vt[7]  = '{6'b001010, 32'h1002, 32'h11223344, 32'h0,        0, 0, 1, 4'b1100, 32'h33443344, 32'h1002,    0, 0, 0};
        vt[8]  = '{6'b001010, 32'h1000, 32'h11223344, 32'h0,        0, 0, 1, 4'b0011, 32'h33443344, 32'h1000,    0, 0, 0};
        vt[9]  = '{6'b001001, 32'h1001, 32'h0,        32'h0,        1, 0, 0, 4'h0,   32'h0,        32'h1001,     0, 1, 1};
        vt[10] = '{6'b010010, 32'h1002, 32'hDEADBEEF, 32'h0,        0, 0, 0, 4'h0,   32'h0,        32'h1002,     0, 1, 1};
        vt[11] = '{6'b000000, 32'h55,   32'h0,        32'h0,        1, 0, 0, 4'h0,   32'h0,        32'h55,       1, 0, 0};
        vt[12] = '{6'b010001, 32'h3000, 32'h0,        32'h0,        1, 1, 0, 4'h0,   32'h0,        32'h3000,     0, 0, 1};
        vt[13] = '{6'b000001, 32'h1001, 32'h0,        32'h11227F44, 1, 0, 1, 4'h0,   32'h0,        32'h0000007F, 1, 0, 0};
        vt[14] = '{6'b010000, 32'h1003, 32'h0,        32'h0,        1, 0, 0, 4'h0,   32'h0,        32'h1003,     1, 0, 0};

        reset = 1'b1; excp_flush = 0; ertn_flush = 0;
        left_valid = 0; ex_pc = 0; ex_result = 0; ex_store_data = 0; ex_op_mem = 0;
        ex_wreg_en = 0; ex_wreg_index = 0; ex_excp = 0;
        data_addr_ok = 0; data_data_ok = 0; data_rdata = 0; right_ready = 0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_right_valid", {63'd0, right_valid}, 64'd0);
        chk("rst_data_req",    {63'd0, data_req}, 64'd0);
        chk("rst_result",      {32'd0, mem_result}, 64'd0);
        chk("rst_bypass",      {26'd0, mem_bypass}, 64'd0);
        chk("rst_busy",        {63'd0, mem_load_busy}, 64'd0);
        chk("rst_wstrb",       {60'd0, data_wstrb}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        right_ready = 1'b1;

        for (int i = 0; i < NV; i++) begin
            issue(vt[i].op, vt[i].addr, vt[i].sdata, vt[i].wen_in, 5'd9, vt[i].exc_in);
            chk($sformatf("v%0d_req", i), {63'd0, data_req}, {63'd0, vt[i].exp_req});
            if (vt[i].exp_req) begin
                chk($sformatf("v%0d_wr", i), {63'd0, data_wr}, {63'd0, vt[i].op[1]});
                chk($sformatf("v%0d_wstrb", i), {60'd0, data_wstrb}, {60'd0, vt[i].exp_wstrb});
                chk($sformatf("v%0d_addr", i), {32'd0, data_addr}, {32'd0, vt[i].addr});
                if (vt[i].op[1]) begin
                    chk($sformatf("v%0d_wdata", i), {32'd0, data_wdata}, {32'd0, vt[i].exp_wdata});
                end
                chk($sformatf("v%0d_busy", i), {63'd0, mem_load_busy}, 64'd1);
                chk($sformatf("v%0d_rv_early", i), {63'd0, right_valid}, 64'd0);
                data_addr_ok = 1'b1;
                @(negedge clk);
                data_addr_ok = 1'b0;
                data_data_ok = 1'b1;
                data_rdata   = vt[i].rdata;
                #1 chk($sformatf("v%0d_req_drop", i), {63'd0, data_req}, 64'd0);
                @(negedge clk);
                data_data_ok = 1'b0;
                data_rdata   = 32'h0;
                #1;
            end
            chk($sformatf("v%0d_rvalid", i), {63'd0, right_valid}, 64'd1);
            chk($sformatf("v%0d_result", i), {32'd0, mem_result}, {32'd0, vt[i].exp_result});
            chk($sformatf("v%0d_pc", i), {32'd0, mem_pc}, {32'd0, 32'h8000_0000 + vt[i].addr});
            chk($sformatf("v%0d_wen", i), {63'd0, mem_wreg_en}, {63'd0, vt[i].exp_wen});
            chk($sformatf("v%0d_ale", i), {63'd0, mem_ale}, {63'd0, vt[i].exp_ale});
            chk($sformatf("v%0d_excp", i), {63'd0, mem_excp}, {63'd0, vt[i].exp_excp});
            if (vt[i].exp_ale) begin
                chk($sformatf("v%0d_badv", i), {32'd0, mem_badv}, {32'd0, vt[i].addr});
            end
            @(negedge clk);
            #1 chk($sformatf("v%0d_bubble", i), {63'd0, right_valid}, 64'd0);
        end

        // Flush while waiting for data: cancel until the late response, then drop it.
        issue(6'b010001, 32'h3000, 32'h0, 1'b1, 5'd2, 1'b0);
        chk("fw_req", {63'd0, data_req}, 64'd1);
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        excp_flush   = 1'b1;
        #1 chk("fw_lr_flush", {63'd0, left_ready}, 64'd0);
        @(negedge clk);
        excp_flush = 1'b0;
        #1;
        chk("fw_cancel_lr1", {63'd0, left_ready}, 64'd0);
        chk("fw_cancel_rv", {63'd0, right_valid}, 64'd0);
        chk("fw_cancel_busy", {63'd0, mem_load_busy}, 64'd0);
        @(negedge clk);
        #1 chk("fw_cancel_lr2", {63'd0, left_ready}, 64'd0);
        @(negedge clk);
        data_data_ok = 1'b1;
        data_rdata   = 32'hBAD0BAD0;
        #1 chk("fw_cancel_lr3", {63'd0, left_ready}, 64'd0);
        @(negedge clk);
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        #1;
        chk("fw_idle_lr", {63'd0, left_ready}, 64'd1);
        chk("fw_no_rv", {63'd0, right_valid}, 64'd0);
        chk("fw_discard", {32'd0, mem_result}, 64'h3000);

        // Flush in REQ with no address handshake: request withdrawn next cycle.
        issue(6'b010001, 32'h3100, 32'h0, 1'b1, 5'd2, 1'b0);
        chk("fr_req", {63'd0, data_req}, 64'd1);
        ertn_flush = 1'b1;
        @(negedge clk);
        ertn_flush = 1'b0;
        #1;
        chk("fr_req_drop", {63'd0, data_req}, 64'd0);
        chk("fr_lr", {63'd0, left_ready}, 64'd1);
        chk("fr_rv", {63'd0, right_valid}, 64'd0);

        // Flush coincident with addr_ok: must wait out the response in CANCEL.
        issue(6'b010001, 32'h3200, 32'h0, 1'b1, 5'd2, 1'b0);
        excp_flush   = 1'b1;
        data_addr_ok = 1'b1;
        @(negedge clk);
        excp_flush   = 1'b0;
        data_addr_ok = 1'b0;
        #1;
        chk("fc_req_drop", {63'd0, data_req}, 64'd0);
        chk("fc_cancel_lr", {63'd0, left_ready}, 64'd0);
        @(negedge clk);
        data_data_ok = 1'b1;
        #1 chk("fc_cancel_lr2", {63'd0, left_ready}, 64'd0);
        @(negedge clk);
        data_data_ok = 1'b0;
        #1;
        chk("fc_idle_lr", {63'd0, left_ready}, 64'd1);
        chk("fc_rv", {63'd0, right_valid}, 64'd0);

        // Back-to-back ALU results with writeback stalled for two cycles.
        @(negedge clk);
        right_ready   = 1'b0;
        left_valid    = 1'b1;
        ex_op_mem     = 6'b000000;
        ex_result     = 32'h5;
        ex_wreg_en    = 1'b1;
        ex_wreg_index = 5'd3;
        ex_excp       = 1'b0;
        #1 chk("bb_lr0", {63'd0, left_ready}, 64'd1);
        @(negedge clk);
        ex_result     = 32'h6;
        ex_wreg_index = 5'd4;
        #1;
        chk("bb_rv1", {63'd0, right_valid}, 64'd1);
        chk("bb_res1", {32'd0, mem_result}, 64'h5);
        chk("bb_lr1", {63'd0, left_ready}, 64'd0);
        chk("bb_bypass", {26'd0, mem_bypass}, {26'd0, 32'h5, 5'd3, 1'b1});
        @(negedge clk);
        #1;
        chk("bb_res2", {32'd0, mem_result}, 64'h5);
        chk("bb_lr2", {63'd0, left_ready}, 64'd0);
        @(negedge clk);
        right_ready = 1'b1;
        #1 chk("bb_lr3", {63'd0, left_ready}, 64'd1);
        @(negedge clk);
        left_valid = 1'b0;
        #1;
        chk("bb_rv4", {63'd0, right_valid}, 64'd1);
        chk("bb_res4", {32'd0, mem_result}, 64'h6);
        chk("bb_idx4", {59'd0, mem_wreg_index}, 64'd4);
        @(negedge clk);
        #1 chk("bb_rv5", {63'd0, right_valid}, 64'd0);

        // Reset in the middle of an access abandons it immediately.
        issue(6'b010001, 32'h4000, 32'h0, 1'b1, 5'd5, 1'b0);
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mr_req", {63'd0, data_req}, 64'd0);
        chk("mr_busy", {63'd0, mem_load_busy}, 64'd0);
        chk("mr_rv", {63'd0, right_valid}, 64'd0);
        chk("mr_lr", {63'd0, left_ready}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
